// File: rtl/ap3_fifo_reader.sv
// Drains a fixed-latency RAM FIFO into a valid/ready stream and sequences FIFO flushes.
// Define AP3_FIFO_READER_COUNT_EN to add the WORD_CNT stream handshake counter.
module ap3_fifo_reader #(
    parameter int RD_LAT       = 1,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        RCLK,
    input  logic        QRT,
    input  logic        EN,
    input  logic        FLUSH_REQ,
    input  logic [3:0]  FFLAGS,
    input  logic [31:0] RDATA,
    output logic        REN,
    output logic        FFLUSH,
    output logic [31:0] M_DATA,
    output logic        M_VALID,
    input  logic        M_READY,
    output logic        BUSY
`ifdef AP3_FIFO_READER_COUNT_EN
    ,
    output logic [15:0] WORD_CNT
`endif
);

    localparam int DEPTH = RD_LAT + 1;

    if (RD_LAT < 1 || RD_LAT > 2) begin : g_bad_rd_lat
        $error("ap3_fifo_reader: RD_LAT must be 1 or 2");
    end
    if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 15) begin : g_bad_flush_cycles
        $error("ap3_fifo_reader: FLUSH_CYCLES must be in 1..15");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        FLUSH   = 2'd2,
        RECOVER = 2'd3
    } state_t;

    state_t      state;
    logic [3:0]  seq_cnt;
    logic        ren_last;

    logic [31:0] mem [4];
    logic [1:0]  wr_ptr;
    logic [1:0]  rd_ptr;
    logic [1:0]  occ;
    logic [RD_LAT-1:0] pipe;
    logic [RD_LAT:0]   pipe_ext;
    logic [1:0]  in_flight;
    logic [2:0]  demand;

    logic        pop;
    logic        capture;
    logic        flush_go;
    logic        unused_flags;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'(DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    // Stream handshake: a word moves on an edge where M_VALID and M_READY are both 1;
    // M_VALID never drops and M_DATA never changes until that edge.
    assign M_VALID = (occ != 2'd0);
    assign M_DATA  = mem[rd_ptr];
    assign pop     = M_VALID && M_READY;

    assign capture  = pipe[RD_LAT-1];
    assign pipe_ext = {pipe, REN};
    assign flush_go = FLUSH_REQ && ((state == IDLE) || (state == RUN));

    always_comb begin
        in_flight = 2'd0;
        for (int i = 0; i < RD_LAT; i++) begin
            in_flight = in_flight + {1'b0, pipe[i]};
        end
    end

    // Credit the word leaving this edge so a full-rate stream keeps REN high every cycle.
    assign demand = {1'b0, occ} + {1'b0, in_flight} - {2'b00, pop};

    assign REN = (state == RUN) && EN && !FLUSH_REQ && !FFLAGS[0]
               && (demand < 3'(DEPTH))
               && (!ren_last || !FFLAGS[1]);

    assign unused_flags = ^FFLAGS[3:2];

    always_ff @(posedge RCLK) begin
        if (QRT) begin
            state    <= IDLE;
            FFLUSH   <= 1'b0;
            BUSY     <= 1'b0;
            seq_cnt  <= 4'd0;
            ren_last <= 1'b0;
        end else begin
            ren_last <= REN;
            case (state)
                IDLE: begin
                    if (flush_go) begin
                        state   <= FLUSH;
                        FFLUSH  <= 1'b1;
                        BUSY    <= 1'b1;
                        seq_cnt <= 4'(FLUSH_CYCLES - 1);
                    end else if (EN) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (flush_go) begin
                        state   <= FLUSH;
                        FFLUSH  <= 1'b1;
                        BUSY    <= 1'b1;
                        seq_cnt <= 4'(FLUSH_CYCLES - 1);
                    end else if (!EN && (pipe == '0)) begin
                        state <= IDLE;
                    end
                end
                FLUSH: begin
                    if (seq_cnt == 4'd0) begin
                        state   <= RECOVER;
                        FFLUSH  <= 1'b0;
                        seq_cnt <= 4'(RD_LAT);
                    end else begin
                        seq_cnt <= seq_cnt - 4'd1;
                    end
                end
                RECOVER: begin
                    if (seq_cnt == 4'd0) begin
                        state <= EN ? RUN : IDLE;
                        BUSY  <= 1'b0;
                    end else begin
                        seq_cnt <= seq_cnt - 4'd1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    FFLUSH <= 1'b0;
                    BUSY   <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge RCLK) begin
        if (QRT) begin
            pipe   <= '0;
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            occ    <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                mem[i] <= 32'd0;
            end
        end else if (flush_go) begin
            pipe   <= '0;
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            occ    <= 2'd0;
        end else begin
            pipe <= pipe_ext[RD_LAT-1:0];
            if (capture) begin
                mem[wr_ptr] <= RDATA;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            occ <= occ + {1'b0, capture} - {1'b0, pop};
        end
    end

`ifdef AP3_FIFO_READER_COUNT_EN
    logic [15:0] word_cnt;

    always_ff @(posedge RCLK) begin
        if (QRT || flush_go) begin
            word_cnt <= 16'd0;
        end else if (pop) begin
            word_cnt <= word_cnt + 16'd1;
        end
    end

    assign WORD_CNT = word_cnt;
`endif

endmodule

// File: tb/tb_ap3_fifo_reader.sv
// Directed bench for ap3_fifo_reader: RD_LAT=1 and RD_LAT=2 instances, each fed by a RAM FIFO model.
// Counter checks run only when AP3_FIFO_READER_COUNT_EN is defined.
module tb_ap3_fifo_reader;

    localparam int PERIOD = 10;

    logic clk = 1'b0;
    always #(PERIOD / 2) clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    logic qrt = 1'b1;

    // Instance 1: RD_LAT=1
    logic        en1 = 1'b0, flush_req1 = 1'b0, mready1 = 1'b0;
    logic [3:0]  fflags1;
    logic [31:0] rdata1, mdata1;
    logic        ren1, fflush1, mv1, busy1;
    logic [31:0] ram1 [4];
    int          rd1 = 0, wr1 = 0;
    logic [31:0] d1 = 32'd0;
`ifdef AP3_FIFO_READER_COUNT_EN
    logic [15:0] word_cnt1;
`endif

    assign fflags1 = {3'b000, rd1 == wr1};
    assign rdata1  = d1;

    always @(posedge clk) begin
        if (fflush1) begin
            rd1 <= wr1;
        end else if (ren1 && (rd1 != wr1)) begin
            d1  <= ram1[rd1 % 4];
            rd1 <= rd1 + 1;
        end
    end

    ap3_fifo_reader #(.RD_LAT(1), .FLUSH_CYCLES(2)) u_dut1 (
        .RCLK(clk), .QRT(qrt), .EN(en1), .FLUSH_REQ(flush_req1),
        .FFLAGS(fflags1), .RDATA(rdata1), .REN(ren1), .FFLUSH(fflush1),
        .M_DATA(mdata1), .M_VALID(mv1), .M_READY(mready1), .BUSY(busy1)
`ifdef AP3_FIFO_READER_COUNT_EN
        , .WORD_CNT(word_cnt1)
`endif
    );

    // Instance 2: RD_LAT=2, RAM word at index i is word2(i)
    logic        en2 = 1'b0, flush_req2 = 1'b0, mready2 = 1'b0, ae_mode2 = 1'b0;
    logic [3:0]  fflags2;
    logic [31:0] rdata2, mdata2;
    logic        ren2, fflush2, mv2, busy2;
    int          rd2 = 0, wr2 = 0;
    logic [31:0] d2a = 32'd0, d2b = 32'd0;
`ifdef AP3_FIFO_READER_COUNT_EN
    logic [15:0] word_cnt2;
`endif

    function automatic logic [31:0] word2(input int i);
        return 32'hC0DE_0000 ^ 32'(i);
    endfunction

    assign fflags2 = {2'b00, ae_mode2 && ((wr2 - rd2) <= 1), rd2 == wr2};
    assign rdata2  = d2b;

    always @(posedge clk) begin
        if (fflush2) begin
            rd2 <= wr2;
        end else if (ren2 && (rd2 != wr2)) begin
            d2a <= word2(rd2);
            rd2 <= rd2 + 1;
        end
        d2b <= d2a;
    end

    ap3_fifo_reader #(.RD_LAT(2), .FLUSH_CYCLES(2)) u_dut2 (
        .RCLK(clk), .QRT(qrt), .EN(en2), .FLUSH_REQ(flush_req2),
        .FFLAGS(fflags2), .RDATA(rdata2), .REN(ren2), .FFLUSH(fflush2),
        .M_DATA(mdata2), .M_VALID(mv2), .M_READY(mready2), .BUSY(busy2)
`ifdef AP3_FIFO_READER_COUNT_EN
        , .WORD_CNT(word_cnt2)
`endif
    );

    // Scoreboard for instance 2: every handshake must match the head of exp_q
    logic [31:0] exp_q[$];

    always @(negedge clk) begin
        if (mv2 && mready2) begin
            if (exp_q.size() == 0) begin
                check("spurious_word", {31'd0, mv2}, 32'd0);
            end else begin
                check("m_data2", mdata2, exp_q.pop_front());
            end
        end
    end

    task automatic push2(input int n, input bit expect_out);
        for (int i = 0; i < n; i++) begin
            if (expect_out) exp_q.push_back(word2(wr2 + i));
        end
        wr2 = wr2 + n;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0) && (n < budget)) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    logic        exp_ren1 [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic        exp_mv1  [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] exp_md1  [7] = '{32'h0, 32'h0, 32'h0, 32'h11, 32'h22, 32'h33, 32'h0};
    logic        exp_ren_ae [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic        exp_ffl  [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic        exp_busy [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [15:0] exp_cnt  [3] = '{16'hFFFF, 16'h0000, 16'h0001};

    initial begin
        int pulses;

        // Reset
        repeat (3) step();
        qrt = 1'b0;
        @(negedge clk);
        check("rst_ren2", {31'd0, ren2}, 32'd0);
        check("rst_fflush2", {31'd0, fflush2}, 32'd0);
        check("rst_busy2", {31'd0, busy2}, 32'd0);
        check("rst_mvalid2", {31'd0, mv2}, 32'd0);
        check("rst_mdata2", mdata2, 32'd0);
        check("rst_state2", 32'(u_dut2.state), 32'd0);
        check("rst_mvalid1", {31'd0, mv1}, 32'd0);
        check("rst_mdata1", mdata1, 32'd0);
`ifdef AP3_FIFO_READER_COUNT_EN
        check("rst_word_cnt2", {16'd0, word_cnt2}, 32'd0);
`endif

        // RD_LAT=1: three preloaded words at full rate
        step();
        ram1[0] = 32'h11;
        ram1[1] = 32'h22;
        ram1[2] = 32'h33;
        wr1 = 3;
        mready1 = 1'b1;
        en1 = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check($sformatf("lat1_ren_c%0d", i), {31'd0, ren1}, {31'd0, exp_ren1[i]});
            check($sformatf("lat1_mvalid_c%0d", i), {31'd0, mv1}, {31'd0, exp_mv1[i]});
            if (exp_mv1[i]) check($sformatf("lat1_mdata_c%0d", i), mdata1, exp_md1[i]);
        end

        // RD_LAT=2: 8 words queued with back-pressure
        step();
        mready2 = 1'b0;
        push2(8, 1'b1);
        en2 = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (ren2) pulses++;
        end
        check("stall_ren_pulses", 32'(pulses), 32'd3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_mvalid", {31'd0, mv2}, 32'd1);
            check("stall_mdata_hold", mdata2, word2(0));
        end
        step();
        mready2 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("sustain_ren_c%0d", i), {31'd0, ren2}, (i < 5) ? 32'd1 : 32'd0);
        end
        wait_drain("drain_eight", 50);

        // Almost-empty: no back-to-back reads, none while empty
        step();
        ae_mode2 = 1'b1;
        push2(3, 1'b1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("ae_ren_c%0d", i), {31'd0, ren2}, {31'd0, exp_ren_ae[i]});
        end
        wait_drain("drain_ae", 30);
        step();
        ae_mode2 = 1'b0;

        // Flush with two buffered words; FLUSH_REQ held into FLUSH is ignored
        mready2 = 1'b0;
        push2(2, 1'b0);
        repeat (8) @(negedge clk);
        check("pre_flush_mvalid", {31'd0, mv2}, 32'd1);
        step();
        flush_req2 = 1'b1;
        @(negedge clk);
        check("pre_flush_busy", {31'd0, busy2}, 32'd0);
        for (int i = 0; i < 7; i++) begin
            step();
            if (i == 1) flush_req2 = 1'b0;
            mready2 = 1'b1;
            @(negedge clk);
            check($sformatf("flush_fflush_c%0d", i), {31'd0, fflush2}, {31'd0, exp_ffl[i]});
            check($sformatf("flush_busy_c%0d", i), {31'd0, busy2}, {31'd0, exp_busy[i]});
            check($sformatf("flush_mvalid_c%0d", i), {31'd0, mv2}, 32'd0);
        end
        check("flush_no_delivery", 32'(exp_q.size()), 32'd0);

        // Reset in the second FLUSH cycle
        step();
        flush_req2 = 1'b1;
        step();
        flush_req2 = 1'b0;
        step();
        qrt = 1'b1;
        @(negedge clk);
        check("qrt_flush_active", {31'd0, fflush2}, 32'd1);
        step();
        qrt = 1'b0;
        @(negedge clk);
        check("qrt_fflush", {31'd0, fflush2}, 32'd0);
        check("qrt_busy", {31'd0, busy2}, 32'd0);
        check("qrt_mvalid", {31'd0, mv2}, 32'd0);
        check("qrt_ren", {31'd0, ren2}, 32'd0);
        check("qrt_state", 32'(u_dut2.state), 32'd0);

`ifdef AP3_FIFO_READER_COUNT_EN
        // Handshake counter across the 16-bit wrap, then cleared by a flush
        step();
        qrt = 1'b1;
        step();
        qrt = 1'b0;
        mready2 = 1'b1;
        en2 = 1'b1;
        push2(65534, 1'b1);
        wait_drain("cnt_drain", 70000);
        @(negedge clk);
        check("cnt_preset", {16'd0, word_cnt2}, 32'h0000_FFFE);
        step();
        mready2 = 1'b0;
        push2(3, 1'b1);
        repeat (10) @(negedge clk);
        for (int j = 0; j < 3; j++) begin
            step();
            mready2 = 1'b1;
            step();
            mready2 = 1'b0;
            @(negedge clk);
            check($sformatf("cnt_wrap_%0d", j), {16'd0, word_cnt2}, {16'd0, exp_cnt[j]});
        end
        step();
        flush_req2 = 1'b1;
        step();
        flush_req2 = 1'b0;
        @(negedge clk);
        check("cnt_flush_clear", {16'd0, word_cnt2}, 32'd0);
        repeat (8) @(negedge clk);
`endif

        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ap3_fifo_reader.md
AP3_FIFO_READER -- requirements
Module: ap3_fifo_reader

Interface
REQ-001 SHALL have parameter RD_LAT, default 1, cycles from REN sample to RDATA valid; legal values 1 and 2.
REQ-002 SHALL have parameter FLUSH_CYCLES, default 2, cycles FFLUSH is held high per flush; legal range 1..15.
REQ-003 SHALL use one clock, RCLK; reset QRT is synchronous and active-high.
REQ-004 Ports:
- RCLK  in  1  clock.
- QRT  in  1  synchronous active-high reset.
- EN  in  1  drain enable.
- FLUSH_REQ  in  1  single-cycle flush request.
- FFLAGS  in  4  RAM FIFO flags: [0] empty, [1] almost-empty (UPAE), [2] almost-full, [3] full.
- RDATA  in  32  RAM read data.
- REN  out  1  RAM read enable.
- FFLUSH  out  1  RAM FIFO flush.
- M_DATA  out  32  stream data.
- M_VALID  out  1  stream valid.
- M_READY  in  1  stream ready.
- BUSY  out  1  flush in progress.

Function
REQ-005 SHALL implement FSM states IDLE, RUN, FLUSH and RECOVER.
REQ-006 IDLE->RUN SHALL occur when EN=1; RUN->IDLE SHALL occur when EN=0 and no read is in flight.
REQ-007 FLUSH_REQ=1 in IDLE or RUN SHALL enter FLUSH on the next edge; FLUSH_REQ SHALL be ignored in FLUSH and RECOVER.
REQ-008 FLUSH SHALL drive FFLUSH=1 for exactly FLUSH_CYCLES cycles, then enter RECOVER.
REQ-009 RECOVER SHALL last RD_LAT+1 cycles, then enter RUN if EN=1, else IDLE.
REQ-010 BUSY SHALL be 1 in FLUSH and RECOVER, else 0.
REQ-011 Entering FLUSH SHALL discard the output buffer and all in-flight reads; M_VALID SHALL be 0 in FLUSH and RECOVER.
REQ-012 The output buffer SHALL hold RD_LAT+1 words.
REQ-013 REN SHALL be 1 only in RUN when all of the following hold:
- FFLAGS[0]=0.
- buffer occupancy plus in-flight reads < RD_LAT+1.
- either REN was 0 last cycle or FFLAGS[1]=0.
REQ-014 Each REN=1 cycle SHALL capture RDATA exactly RD_LAT cycles later into the buffer tail, unless the read was discarded by REQ-011.
REQ-015 M_DATA/M_VALID SHALL present the buffer head in FIFO order; a word SHALL be consumed on any edge where M_VALID=1 and M_READY=1.
REQ-016 M_DATA SHALL hold stable while M_VALID=1 and M_READY=0.
REQ-017 With M_READY held 1 and the FIFO not almost-empty, REN SHALL sustain 1 every cycle, giving one word per cycle throughput.
REQ-018 Simultaneous capture and consume on one edge SHALL keep occupancy unchanged and lose no data.
REQ-019 EN falling mid-stream SHALL stop new REN, complete in-flight captures, and keep buffered words presentable.
REQ-020 FFLAGS[2] and FFLAGS[3] SHALL be ignored.

Reset
REQ-021 QRT=1 sampled on an RCLK edge SHALL force the following on that edge, regardless of state, including mid-flush:
- state IDLE.
- REN=0, FFLUSH=0, BUSY=0, M_VALID=0, M_DATA=0.
- buffer empty, in-flight count 0.
REQ-022 QRT SHALL take priority over FLUSH_REQ and EN.

Configuration
REQ-023 With macro AP3_FIFO_READER_COUNT_EN defined, the module SHALL add output WORD_CNT [15:0]:
- cleared by reset and on entry to FLUSH.
- increments by 1 per stream handshake.
- wraps 16'hFFFF->0.
REQ-024 Without AP3_FIFO_READER_COUNT_EN, WORD_CNT and its counter SHALL be absent and all other behaviour identical.

Verification
REQ-025 RD_LAT=1, FIFO preloaded with 0x11,0x22,0x33, FFLAGS[1]=0, EN=1, M_READY=1 -> REN high for 3 consecutive cycles; M_DATA 0x11,0x22,0x33 on consecutive cycles; FIFO empty -> REN=0.
REQ-026 RD_LAT=2, 8 words queued, M_READY=0 -> REN pulses exactly 3 times, M_VALID=1 with M_DATA held at word0; M_READY=1 -> all 8 words out in order, none lost.
REQ-027 FFLAGS[1]=1, one word left -> REN not asserted on consecutive cycles; no read is issued while FFLAGS[0]=1.
REQ-028 FLUSH_REQ pulse with 2 words buffered, FLUSH_CYCLES=2 -> FFLUSH=1 for 2 cycles, BUSY=1 for 2+RD_LAT+1 cycles, M_VALID=0 throughout, buffered words never delivered.
REQ-029 QRT asserted in the second FLUSH cycle -> next edge FFLUSH=0, BUSY=0, M_VALID=0, state IDLE.
REQ-030 With AP3_FIFO_READER_COUNT_EN, WORD_CNT preset near wrap: 3 handshakes from 16'hFFFE -> 16'hFFFF, 0, 1; a flush then clears WORD_CNT to 0.
